leaf_stream_bridge: RTL and testbench
=====================================

# leaf_stream_bridge

Parametrised decoupling bridge between `leaf_interface` and an HLS operator inside a leaf. It supports any number of input and output stream channels. Each channel gets a first-word-fall-through (FWFT) FIFO that converts the interface's vld/ack ports into the operator's TDATA/TVALID/TREADY streams. A start sequencer turns the level `ap_start_user` request into a proper HLS `ap_start`/`ap_ready`/`ap_done` handshake and counts completed runs. It replaces the fixed two-in/four-out direct wiring used in leaf wrappers.

## Interface
Parameters:
- `NUM_IN_PORTS`, 2, stream channels interface→user (1..16)
- `NUM_OUT_PORTS`, 4, stream channels user→interface (1..16)
- `PAYLOAD_BITS`, 32, data width per channel
- `FIFO_DEPTH`, 4, entries per channel FIFO; power of two, ≥2
- `CNT_BITS`, 16, width of the run counter and of each word counter

Ports:
- `clk`  in  1  sole clock
- `ap_rst_n`  in  1  asynchronous, active-low reset
- `ap_start`  in  1  level start request from `leaf_interface` (`ap_start_user`)
- `user_ap_start`  out  1  operator `ap_start`
- `user_ap_ready`  in  1  operator `ap_ready`
- `user_ap_done`  in  1  operator `ap_done`
- `busy`  out  1  high while the sequencer is not IDLE
- `run_cnt`  out  CNT_BITS  completed runs, wraps
- `dout_leaf_interface2user`  in  NUM_IN_PORTS*PAYLOAD_BITS  input data, channel k at bits [k*PAYLOAD_BITS +: PAYLOAD_BITS]
- `vld_interface2user`  in  NUM_IN_PORTS  input valid per channel
- `ack_user2interface`  out  NUM_IN_PORTS  input ready per channel
- `Input_TDATA` / `Input_TVALID`  out  NUM_IN_PORTS*PAYLOAD_BITS / NUM_IN_PORTS  streams to the operator
- `Input_TREADY`  in  NUM_IN_PORTS  operator ready per input stream
- `Output_TDATA` / `Output_TVALID`  in  NUM_OUT_PORTS*PAYLOAD_BITS / NUM_OUT_PORTS  streams from the operator
- `Output_TREADY`  out  NUM_OUT_PORTS  bridge ready per output stream
- `din_leaf_user2interface` / `vld_user2interface`  out  NUM_OUT_PORTS*PAYLOAD_BITS / NUM_OUT_PORTS  data and valid to the interface
- `ack_interface2user`  in  NUM_OUT_PORTS  interface ready per channel
- `word_cnt`  out  (NUM_IN_PORTS+NUM_OUT_PORTS)*CNT_BITS  per-channel transfer counts; inputs occupy the low slices; present only with `LEAF_BRIDGE_CNT_EN`

## Operation
- All handshakes are valid/ready: a transfer occurs on a rising `clk` edge when valid and ready are both high.
- Data path, per channel, one FIFO:
  - Write side: ready = !full. A push while full is never accepted, even if a pop happens in the same cycle.
  - Read side: FWFT. Valid = !empty, and data always shows the head entry.
  - Occupancy counter is log2(FIFO_DEPTH)+1 bits. A simultaneous push and pop leaves occupancy unchanged.
  - Read and write pointers wrap modulo FIFO_DEPTH.
- Start sequencer states:
  - IDLE: `user_ap_start`=0. Goes to START when `ap_start`=1.
  - START: `user_ap_start`=1. Goes to RUN on `user_ap_ready`=1. If `user_ap_done` is also high in that cycle, it goes straight to IDLE and `run_cnt` increments.
  - RUN: `user_ap_start`=0. On `user_ap_done`=1, increments `run_cnt` and goes to IDLE.
  - If `ap_start` is still high on return to IDLE, START is re-entered on the next cycle.
  - Dropping `ap_start` in START or RUN does not abort the run.
- The data path is independent of the sequencer; FIFOs keep accepting and draining in every state.

## Timing
- Reset values: all FIFOs empty, so every `ack_user2interface` and `Output_TREADY` = 1 and every `Input_TVALID` and `vld_user2interface` = 0. Sequencer in IDLE, `user_ap_start`=0, `busy`=0, `run_cnt`=0, `word_cnt`=0.
- Reset asserted mid-operation flushes all FIFO contents immediately (asynchronously); data in flight is lost.
- Latency: a word pushed at edge N is valid on the far side after edge N; one cycle through the bridge.
- Throughput: one word per cycle per channel under continuous flow.
- `user_ap_start` rises one cycle after `ap_start` is sampled high in IDLE.

## Configuration
- `LEAF_BRIDGE_CNT_EN` defined:
  - `word_cnt` port exists.
  - Each channel counts accepted pushes on its write side, wraps at 2^CNT_BITS, and clears to 0 at reset.
- Undefined: the port and all counters are absent; there are no other behavioural differences.

## Structure
- Shared package `leaf_bridge_pkg` holds:
  - the sequencer state enum (IDLE, START, RUN);
  - a function `clog2` for pointer widths.
- One sub-module, `leaf_stream_fifo` (parametrised PAYLOAD_BITS, FIFO_DEPTH), instantiated in generate loops, once per input channel and once per output channel.

## Test plan
- **Reset:** assert `ap_rst_n`=0 mid-stream with 3 words queued → all valids 0 and readies 1 on the same cycle; after release no stale word appears.
- **Fill and full:** push 5 words with FIFO_DEPTH=4 and `Input_TREADY`=0 → `ack_user2interface[0]` drops after the 4th push. Release ready → words 0xA0..0xA3 emerge in order, and the 5th word is accepted once space frees.
- **Simultaneous push/pop:** occupancy 1, push 0x55 and pop the head in the same cycle → occupancy stays 1 and the head becomes 0x55.
- **Full push with pop:** FIFO full, push and pop in the same cycle → pop succeeds, push is refused (ack=0).
- **Sequencer:** `ap_start`=1, `user_ap_ready` 2 cycles later, `user_ap_done` 5 cycles later → `user_ap_start` is high for exactly 3 cycles, `run_cnt`=1, and `busy` falls the cycle after done. Holding `ap_start` high restarts a run.
- **Counters (`LEAF_BRIDGE_CNT_EN`):** 10 words on output channel 3 → its `word_cnt` slice = 10; all other slices stay 0.

Source files
------------

// File: rtl/leaf_bridge_pkg.sv
// leaf_bridge_pkg
//   Shared definitions for leaf_stream_bridge and its channel FIFO:
//   - seq_state_e : start sequencer state (IDLE, START, RUN)
//   - clog2       : ceiling log2, used to size FIFO pointers
package leaf_bridge_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    RUN   = 2'd2
  } seq_state_e;

  // Smallest r with 2**r >= value (0 for value <= 1).
  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/leaf_stream_fifo.sv
// leaf_stream_fifo
//   First-word-fall-through FIFO for one bridge channel.
//   Parameters: PAYLOAD_BITS (word width), FIFO_DEPTH (power of two, >= 2).
//   Ports:
//     clk, rst_n            clock, asynchronous active-low reset (flushes contents)
//     wr_data/wr_valid/wr_ready  write side; wr_ready = !full
//     rd_data/rd_valid/rd_ready  read side; rd_valid = !empty, rd_data = head entry
//   Handshake: a word moves on a rising clk edge when valid and ready are both
//   high on that side. A push while full is refused even if a pop happens in the
//   same cycle, so wr_ready never depends on rd_ready.
module leaf_stream_fifo
  import leaf_bridge_pkg::*;
#(
  parameter int PAYLOAD_BITS = 32,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [PAYLOAD_BITS-1:0] wr_data,
  input  logic                    wr_valid,
  output logic                    wr_ready,
  output logic [PAYLOAD_BITS-1:0] rd_data,
  output logic                    rd_valid,
  input  logic                    rd_ready
);

  localparam int AW = clog2(FIFO_DEPTH);

  logic [PAYLOAD_BITS-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0]           wr_ptr;
  logic [AW-1:0]           rd_ptr;
  logic [AW:0]             count;
  logic                    full;
  logic                    empty;
  logic                    push;
  logic                    pop;

  assign full     = (count == (AW+1)'(FIFO_DEPTH));
  assign empty    = (count == '0);
  assign push     = wr_valid & ~full;
  assign pop      = rd_ready & ~empty;
  assign wr_ready = ~full;
  assign rd_valid = ~empty;
  assign rd_data  = mem[rd_ptr];

  // Pointers are AW bits wide, so they wrap modulo FIFO_DEPTH naturally.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage needs no reset: an empty count hides whatever it holds.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= wr_data;
  end

endmodule

// File: rtl/leaf_stream_bridge.sv
// leaf_stream_bridge
//   Decoupling bridge between leaf_interface and an HLS operator.
//   Optional feature macro: LEAF_BRIDGE_CNT_EN (adds word_cnt and per-channel
//   push counters).
//   Ports:
//     clk, ap_rst_n                       clock, asynchronous active-low reset
//     ap_start                            level start request from the interface
//     user_ap_start/ready/done            HLS control handshake to the operator
//     busy, run_cnt                       sequencer not IDLE, completed runs (wraps)
//     dbg_seq_state                       current sequencer state
//     dout_leaf_interface2user, vld_interface2user, ack_user2interface
//                                         interface -> bridge input channels
//     Input_TDATA/TVALID/TREADY           bridge -> operator streams
//     Output_TDATA/TVALID/TREADY          operator -> bridge streams
//     din_leaf_user2interface, vld_user2interface, ack_interface2user
//                                         bridge -> interface output channels
//     word_cnt                            accepted pushes per channel, inputs in
//                                         the low slices (LEAF_BRIDGE_CNT_EN only)
//   Channel k of a packed bus lives at [k*PAYLOAD_BITS +: PAYLOAD_BITS].
module leaf_stream_bridge
  import leaf_bridge_pkg::*;
#(
  parameter int NUM_IN_PORTS  = 2,
  parameter int NUM_OUT_PORTS = 4,
  parameter int PAYLOAD_BITS  = 32,
  parameter int FIFO_DEPTH    = 4,
  parameter int CNT_BITS      = 16
) (
  input  logic                                    clk,
  input  logic                                    ap_rst_n,
  input  logic                                    ap_start,
  output logic                                    user_ap_start,
  input  logic                                    user_ap_ready,
  input  logic                                    user_ap_done,
  output logic                                    busy,
  output logic [CNT_BITS-1:0]                     run_cnt,
  output seq_state_e                              dbg_seq_state,
  input  logic [NUM_IN_PORTS*PAYLOAD_BITS-1:0]    dout_leaf_interface2user,
  input  logic [NUM_IN_PORTS-1:0]                 vld_interface2user,
  output logic [NUM_IN_PORTS-1:0]                 ack_user2interface,
  output logic [NUM_IN_PORTS*PAYLOAD_BITS-1:0]    Input_TDATA,
  output logic [NUM_IN_PORTS-1:0]                 Input_TVALID,
  input  logic [NUM_IN_PORTS-1:0]                 Input_TREADY,
  input  logic [NUM_OUT_PORTS*PAYLOAD_BITS-1:0]   Output_TDATA,
  input  logic [NUM_OUT_PORTS-1:0]                Output_TVALID,
  output logic [NUM_OUT_PORTS-1:0]                Output_TREADY,
  output logic [NUM_OUT_PORTS*PAYLOAD_BITS-1:0]   din_leaf_user2interface,
  output logic [NUM_OUT_PORTS-1:0]                vld_user2interface,
`ifdef LEAF_BRIDGE_CNT_EN
  output logic [(NUM_IN_PORTS+NUM_OUT_PORTS)*CNT_BITS-1:0] word_cnt,
`endif
  input  logic [NUM_OUT_PORTS-1:0]                ack_interface2user
);

  // ---------------- start sequencer ----------------
  seq_state_e state_q;
  seq_state_e state_d;
  logic       run_done;

  always_ff @(posedge clk or negedge ap_rst_n) begin
    if (!ap_rst_n) state_q <= IDLE;
    else           state_q <= state_d;
  end

  // A done seen together with ready in START completes the run immediately.
  always_comb begin
    state_d  = state_q;
    run_done = 1'b0;
    case (state_q)
      IDLE:  if (ap_start) state_d = START;
      START: begin
        if (user_ap_ready) begin
          if (user_ap_done) begin
            state_d  = IDLE;
            run_done = 1'b1;
          end else begin
            state_d  = RUN;
          end
        end
      end
      RUN: begin
        if (user_ap_done) begin
          state_d  = IDLE;
          run_done = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    user_ap_start = (state_q == START);
    busy          = (state_q != IDLE);
    dbg_seq_state = state_q;
  end

  always_ff @(posedge clk or negedge ap_rst_n) begin
    if (!ap_rst_n)     run_cnt <= '0;
    else if (run_done) run_cnt <= run_cnt + CNT_BITS'(1);
  end

  // ---------------- data path ----------------
  for (genvar k = 0; k < NUM_IN_PORTS; k++) begin : g_in
    leaf_stream_fifo #(
      .PAYLOAD_BITS (PAYLOAD_BITS),
      .FIFO_DEPTH   (FIFO_DEPTH)
    ) u_fifo (
      .clk      (clk),
      .rst_n    (ap_rst_n),
      .wr_data  (dout_leaf_interface2user[k*PAYLOAD_BITS +: PAYLOAD_BITS]),
      .wr_valid (vld_interface2user[k]),
      .wr_ready (ack_user2interface[k]),
      .rd_data  (Input_TDATA[k*PAYLOAD_BITS +: PAYLOAD_BITS]),
      .rd_valid (Input_TVALID[k]),
      .rd_ready (Input_TREADY[k])
    );
  end

  for (genvar k = 0; k < NUM_OUT_PORTS; k++) begin : g_out
    leaf_stream_fifo #(
      .PAYLOAD_BITS (PAYLOAD_BITS),
      .FIFO_DEPTH   (FIFO_DEPTH)
    ) u_fifo (
      .clk      (clk),
      .rst_n    (ap_rst_n),
      .wr_data  (Output_TDATA[k*PAYLOAD_BITS +: PAYLOAD_BITS]),
      .wr_valid (Output_TVALID[k]),
      .wr_ready (Output_TREADY[k]),
      .rd_data  (din_leaf_user2interface[k*PAYLOAD_BITS +: PAYLOAD_BITS]),
      .rd_valid (vld_user2interface[k]),
      .rd_ready (ack_interface2user[k])
    );
  end

`ifdef LEAF_BRIDGE_CNT_EN
  // ---------------- per-channel push counters ----------------
  localparam int NCH = NUM_IN_PORTS + NUM_OUT_PORTS;

  logic [NCH-1:0] ch_push;
  assign ch_push = {Output_TVALID & Output_TREADY,
                    vld_interface2user & ack_user2interface};

  for (genvar k = 0; k < NCH; k++) begin : g_cnt
    logic [CNT_BITS-1:0] cnt_q;
    always_ff @(posedge clk or negedge ap_rst_n) begin
      if (!ap_rst_n)       cnt_q <= '0;
      else if (ch_push[k]) cnt_q <= cnt_q + CNT_BITS'(1);
    end
    assign word_cnt[k*CNT_BITS +: CNT_BITS] = cnt_q;
  end
`endif

endmodule

// File: tb/tb_leaf_stream_bridge.sv
// tb_leaf_stream_bridge
//   Bench for leaf_stream_bridge with default parameters. Each channel is
//   modelled as a bounded queue of words; the sequencer is exercised with
//   fixed scenarios whose outcomes are stated as constants.
module tb_leaf_stream_bridge;

  localparam int NI    = 2;
  localparam int NO    = 4;
  localparam int PB    = 32;
  localparam int DEPTH = 4;
  localparam int CW    = 16;
  localparam int NCH   = NI + NO;

  // ---------------- clock / reset / DUT signals ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              ap_rst_n;
  logic              ap_start;
  logic              user_ap_start;
  logic              user_ap_ready;
  logic              user_ap_done;
  logic              busy;
  logic [CW-1:0]     run_cnt;
  logic [1:0]        dbg_seq_state;
  logic [NI*PB-1:0]  din_in;
  logic [NI-1:0]     vld_in;
  logic [NI-1:0]     ack_user2interface;
  logic [NI*PB-1:0]  Input_TDATA;
  logic [NI-1:0]     Input_TVALID;
  logic [NI-1:0]     in_tready;
  logic [NO*PB-1:0]  out_tdata;
  logic [NO-1:0]     out_tvalid;
  logic [NO-1:0]     Output_TREADY;
  logic [NO*PB-1:0]  din_leaf_user2interface;
  logic [NO-1:0]     vld_user2interface;
  logic [NO-1:0]     ack_out;
`ifdef LEAF_BRIDGE_CNT_EN
  logic [NCH*CW-1:0] word_cnt;
`endif

  leaf_stream_bridge #(
    .NUM_IN_PORTS  (NI),
    .NUM_OUT_PORTS (NO),
    .PAYLOAD_BITS  (PB),
    .FIFO_DEPTH    (DEPTH),
    .CNT_BITS      (CW)
  ) dut (
    .clk                      (clk),
    .ap_rst_n                 (ap_rst_n),
    .ap_start                 (ap_start),
    .user_ap_start            (user_ap_start),
    .user_ap_ready            (user_ap_ready),
    .user_ap_done             (user_ap_done),
    .busy                     (busy),
    .run_cnt                  (run_cnt),
    .dbg_seq_state            (dbg_seq_state),
    .dout_leaf_interface2user (din_in),
    .vld_interface2user       (vld_in),
    .ack_user2interface       (ack_user2interface),
    .Input_TDATA              (Input_TDATA),
    .Input_TVALID             (Input_TVALID),
    .Input_TREADY             (in_tready),
    .Output_TDATA             (out_tdata),
    .Output_TVALID            (out_tvalid),
    .Output_TREADY            (Output_TREADY),
    .din_leaf_user2interface  (din_leaf_user2interface),
    .vld_user2interface       (vld_user2interface),
`ifdef LEAF_BRIDGE_CNT_EN
    .word_cnt                 (word_cnt),
`endif
    .ack_interface2user       (ack_out)
  );

  // ---------------- scoreboard ----------------
  int n_vec = 0;
  int n_err = 0;
  logic [PB-1:0] exp_q [NCH][$];
  int unsigned   push_total [NCH];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Channel views: 0..NI-1 are input channels, NI.. are output channels.
  function automatic logic ch_wr_valid(int ch);
    if (ch < NI) return vld_in[ch];
    return out_tvalid[ch-NI];
  endfunction
  function automatic logic [PB-1:0] ch_wr_data(int ch);
    if (ch < NI) return din_in[ch*PB +: PB];
    return out_tdata[(ch-NI)*PB +: PB];
  endfunction
  function automatic logic ch_rd_ready(int ch);
    if (ch < NI) return in_tready[ch];
    return ack_out[ch-NI];
  endfunction
  function automatic logic ch_wr_ready(int ch);
    if (ch < NI) return ack_user2interface[ch];
    return Output_TREADY[ch-NI];
  endfunction
  function automatic logic ch_rd_valid(int ch);
    if (ch < NI) return Input_TVALID[ch];
    return vld_user2interface[ch-NI];
  endfunction
  function automatic logic [PB-1:0] ch_rd_data(int ch);
    if (ch < NI) return Input_TDATA[ch*PB +: PB];
    return din_leaf_user2interface[(ch-NI)*PB +: PB];
  endfunction

  // Outputs against the queues as they stand after the last edge.
  task automatic check_channels();
    for (int ch = 0; ch < NCH; ch++) begin
      check($sformatf("ready%0d", ch), 64'(ch_wr_ready(ch)), 64'(exp_q[ch].size() < DEPTH));
      check($sformatf("valid%0d", ch), 64'(ch_rd_valid(ch)), 64'(exp_q[ch].size() > 0));
      if (exp_q[ch].size() > 0)
        check($sformatf("data%0d", ch), 64'(ch_rd_data(ch)), 64'(exp_q[ch][0]));
`ifdef LEAF_BRIDGE_CNT_EN
      check($sformatf("wcnt%0d", ch), 64'(word_cnt[ch*CW +: CW]), 64'(CW'(push_total[ch])));
`endif
    end
  endtask

  // Apply the queue rules for the upcoming edge: pop when ready and not
  // empty; push only when not full before this edge.
  task automatic model_edge();
    for (int ch = 0; ch < NCH; ch++) begin
      bit was_full;
      bit do_pop;
      bit do_push;
      was_full = (exp_q[ch].size() == DEPTH);
      do_pop   = ch_rd_ready(ch) && (exp_q[ch].size() > 0);
      do_push  = ch_wr_valid(ch) && !was_full;
      if (do_pop) void'(exp_q[ch].pop_front());
      if (do_push) begin
        exp_q[ch].push_back(ch_wr_data(ch));
        push_total[ch]++;
      end
    end
  endtask

  task automatic model_clear();
    for (int ch = 0; ch < NCH; ch++) begin
      exp_q[ch].delete();
      push_total[ch] = 0;
    end
  endtask

  // Called at a falling edge with inputs already driven.
  task automatic step();
    check_channels();
    model_edge();
    @(posedge clk);
    @(negedge clk);
  endtask

  // ---------------- driver helpers ----------------
  task automatic idle_inputs();
    ap_start      = 1'b0;
    user_ap_ready = 1'b0;
    user_ap_done  = 1'b0;
    din_in        = '0;
    vld_in        = '0;
    in_tready     = '0;
    out_tdata     = '0;
    out_tvalid    = '0;
    ack_out       = '0;
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_ack"},   64'(ack_user2interface), 64'({NI{1'b1}}));
    check({tag, "_otrdy"}, 64'(Output_TREADY),      64'({NO{1'b1}}));
    check({tag, "_itv"},   64'(Input_TVALID),       64'(0));
    check({tag, "_vldo"},  64'(vld_user2interface), 64'(0));
    check({tag, "_start"}, 64'(user_ap_start),      64'(0));
    check({tag, "_busy"},  64'(busy),               64'(0));
    check({tag, "_runs"},  64'(run_cnt),            64'(0));
  endtask

  // ---------------- stimulus ----------------
  int start_hi;
  int pv;
  int pr;

  initial begin
    idle_inputs();
    model_clear();
    ap_rst_n = 1'b0;
    repeat (2) @(negedge clk);
    check_reset_values("rst");
    check_channels();
    ap_rst_n = 1'b1;
    @(negedge clk);

    // Fill input channel 0 with the operator stalled: 5 pushes offered.
    for (int i = 0; i < 5; i++) begin
      vld_in[0]       = 1'b1;
      din_in[0 +: PB] = 32'hA0 + 32'(i);
      if (i == 4) check("full_ack", 64'(ack_user2interface[0]), 64'(0));
      step();
    end
    // Full, push held and pop in the same cycle: pop happens, push refused.
    in_tready[0] = 1'b1;
    check("full_head", 64'(Input_TDATA[0 +: PB]), 64'h0A0);
    check("full_ack2", 64'(ack_user2interface[0]), 64'(0));
    step();
    check("after_pop_ack", 64'(ack_user2interface[0]), 64'(1));
    check("after_pop_head", 64'(Input_TDATA[0 +: PB]), 64'h0A1);
    // Fifth word now accepted; drain everything.
    for (int i = 0; i < 6; i++) begin
      if (i > 0) vld_in[0] = 1'b0;
      step();
    end
    check("drained", 64'(Input_TVALID[0]), 64'(0));

    // Occupancy 1, then simultaneous push 0x55 and pop.
    in_tready[0] = 1'b0;
    vld_in[0] = 1'b1; din_in[0 +: PB] = 32'h11;
    step();
    in_tready[0] = 1'b1; din_in[0 +: PB] = 32'h55;
    step();
    check("pp_valid", 64'(Input_TVALID[0]), 64'(1));
    check("pp_head",  64'(Input_TDATA[0 +: PB]), 64'h55);
    vld_in[0] = 1'b0;
    step();
    check("pp_occ1", 64'(Input_TVALID[0]), 64'(0));
    idle_inputs();

    // Sequencer: ready after 3 cycles of user_ap_start, done 5 cycles later.
    start_hi = 0;
    ap_start = 1'b1;
    step();
    ap_start = 1'b0;
    check("seq_busy_start", 64'(busy), 64'(1));
    for (int i = 0; i < 8; i++) begin
      if (user_ap_start) start_hi++;
      user_ap_ready = (i == 2);
      user_ap_done  = (i == 7);
      step();
      if (i < 7) check($sformatf("seq_busy%0d", i), 64'(busy), 64'(1));
    end
    user_ap_ready = 1'b0; user_ap_done = 1'b0;
    check("seq_start_cycles", 64'(start_hi), 64'(3));
    check("seq_busy_end", 64'(busy), 64'(0));
    check("seq_runs1", 64'(run_cnt), 64'(1));

    // Held ap_start: ready and done together in START finish at once,
    // then START is re-entered on the following cycle.
    ap_start = 1'b1;
    step();
    check("seq2_start", 64'(user_ap_start), 64'(1));
    user_ap_ready = 1'b1; user_ap_done = 1'b1;
    step();
    user_ap_ready = 1'b0; user_ap_done = 1'b0;
    check("seq2_idle", 64'(busy), 64'(0));
    check("seq_runs2", 64'(run_cnt), 64'(2));
    step();
    check("seq3_restart", 64'(user_ap_start), 64'(1));
    user_ap_ready = 1'b1;
    step();
    user_ap_ready = 1'b0;
    ap_start = 1'b0;
    check("seq3_run_start", 64'(user_ap_start), 64'(0));
    check("seq3_run_busy", 64'(busy), 64'(1));
    step();
    check("seq3_noabort", 64'(busy), 64'(1));
    user_ap_done = 1'b1;
    step();
    user_ap_done = 1'b0;
    check("seq_runs3", 64'(run_cnt), 64'(3));
    step();
    check("seq3_stay_idle", 64'(busy), 64'(0));

    // Randomized traffic on all channels with shifting valid/ready bias.
    for (int i = 0; i < 800; i++) begin
      pv = 20 + 20 * ((i / 100) % 4);
      pr = 80 - 20 * ((i / 150) % 4);
      for (int k = 0; k < NI; k++) begin
        vld_in[k]           = ($urandom_range(0, 99) < pv);
        in_tready[k]        = ($urandom_range(0, 99) < pr);
        din_in[k*PB +: PB]  = $urandom;
      end
      for (int k = 0; k < NO; k++) begin
        out_tvalid[k]         = ($urandom_range(0, 99) < pv);
        ack_out[k]            = ($urandom_range(0, 99) < pr);
        out_tdata[k*PB +: PB] = $urandom;
      end
      ap_start = ($urandom_range(0, 3) == 0);
      step();
    end
    idle_inputs();

    // Reset mid-stream with 3 words queued on input channel 0.
    for (int i = 0; i < 3; i++) begin
      vld_in[0] = 1'b1; din_in[0 +: PB] = 32'hC0 + 32'(i);
      step();
    end
    vld_in[0] = 1'b0;
    #2;
    ap_rst_n = 1'b0;
    #1;
    model_clear();
    check_reset_values("midrst");
    @(negedge clk);
    ap_rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      in_tready = '1;
      step();
    end
    check("no_stale", 64'(Input_TVALID), 64'(0));
    idle_inputs();

    // Ten words on output channel 3, drained as they arrive.
    ack_out = '1;
    for (int i = 0; i < 10; i++) begin
      out_tvalid[3] = 1'b1; out_tdata[3*PB +: PB] = $urandom;
      step();
    end
    out_tvalid[3] = 1'b0;
    step();
    step();
`ifdef LEAF_BRIDGE_CNT_EN
    for (int ch = 0; ch < NCH; ch++)
      check($sformatf("cnt_slice%0d", ch), 64'(word_cnt[ch*CW +: CW]),
            (ch == NI + 3) ? 64'd10 : 64'd0);
`endif
    check("out3_drained", 64'(vld_user2interface), 64'(0));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
